// File: rtl/shop_cmd_framer_v_pkg.sv
// Shared constants and types for the shop_v command framer.
// Character codes, FSM state encoding and default widths shared with shop_v.
package shop_cmd_framer_v_pkg;

   localparam int unsigned DefNumChars = 7;
   localparam int unsigned DefUNumBits = 4;

   localparam logic [7:0] ChCr     = 8'h0D;
   localparam logic [7:0] ChLf     = 8'h0A;
   localparam logic [7:0] ChBs     = 8'h08;
   localparam logic [7:0] ChDollar = 8'h24;

   typedef enum logic [1:0] {
      StCollect = 2'd0,
      StUid     = 2'd1,
      StDiscard = 2'd2
   } state_e;

endpackage

// File: rtl/shop_cmd_framer_v.sv
// Serial ASCII command framer: packs characters into a right-justified word and
// strobes complete lines (with optional "$<hex>" user index) towards shop_v.
module shop_cmd_framer_v
   import shop_cmd_framer_v_pkg::*;
#(
   parameter int unsigned A_NUM_CHARS = DefNumChars,
   parameter int unsigned A_NUM_BITS  = A_NUM_CHARS * 8,
   parameter int unsigned U_NUM_BITS  = DefUNumBits
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_char_vld,
   input  logic [7:0]            i_char,
   output logic                  o_rdy,
   output logic [A_NUM_BITS-1:0] o_a,
   output logic [U_NUM_BITS-1:0] o_u,
   output logic                  o_err
);

   localparam int unsigned CntW = $clog2(A_NUM_CHARS + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(A_NUM_CHARS);

   // Returns {valid, value}.
   function automatic logic [4:0] hex_decode(input logic [7:0] ch);
      logic [4:0] r;
      r = 5'd0;
      if (ch >= 8'h30 && ch <= 8'h39) begin
         r = {1'b1, 4'(ch - 8'h30)};
      end else if (ch >= 8'h41 && ch <= 8'h46) begin
         r = {1'b1, 4'(ch - 8'h37)};
      end else if (ch >= 8'h61 && ch <= 8'h66) begin
         r = {1'b1, 4'(ch - 8'h57)};
      end
      return r;
   endfunction

   state_e                state_q, state_d;
   logic [A_NUM_BITS-1:0] buf_q, buf_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [U_NUM_BITS-1:0] uid_q, uid_d;
   logic                  uid_set_q, uid_set_d;
   logic [A_NUM_BITS-1:0] a_q, a_d;
   logic [U_NUM_BITS-1:0] u_q, u_d;
   logic                  rdy_q, rdy_d;
   logic                  err_q, err_d;

   logic       is_term, is_bs, is_print;
   logic [4:0] hex;

   always_comb begin
      is_term  = (i_char == ChCr) || (i_char == ChLf);
      is_bs    = (i_char == ChBs);
      is_print = (i_char >= 8'h20) && (i_char <= 8'h7E);
      hex      = hex_decode(i_char);
   end

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      uid_d     = uid_q;
      uid_set_d = uid_set_q;
      a_d       = a_q;
      u_d       = u_q;
      rdy_d     = 1'b0;
      err_d     = 1'b0;

      if (i_char_vld) begin
         unique case (state_q)
            StCollect: begin
               if (is_print && i_char == ChDollar && cnt_q == '0 && !uid_set_q) begin
                  state_d = StUid;
               end else if (is_print) begin
                  if (cnt_q < CntMax) begin
                     buf_d = {buf_q[A_NUM_BITS-9:0], i_char};
                     cnt_d = cnt_q + 1'b1;
                  end else begin
                     err_d   = 1'b1;
                     state_d = StDiscard;
                  end
               end else if (is_bs) begin
                  // An empty-line backspace leaves any uid prefix intact.
                  if (cnt_q != '0) begin
                     buf_d = buf_q >> 8;
                     cnt_d = cnt_q - 1'b1;
                  end
               end else if (is_term && (cnt_q != '0 || uid_set_q)) begin
                  a_d       = buf_q;
                  u_d       = uid_q;
                  rdy_d     = 1'b1;
                  buf_d     = '0;
                  cnt_d     = '0;
                  uid_d     = '0;
                  uid_set_d = 1'b0;
               end
            end
            StUid: begin
               if (hex[4]) begin
                  uid_d     = U_NUM_BITS'(hex[3:0]);
                  uid_set_d = 1'b1;
                  state_d   = StCollect;
               end else if (is_print) begin
                  err_d   = 1'b1;
                  state_d = StDiscard;
               end else if (is_term) begin
                  // The terminator itself closes the bad line, so no discard phase.
                  err_d     = 1'b1;
                  buf_d     = '0;
                  cnt_d     = '0;
                  uid_d     = '0;
                  uid_set_d = 1'b0;
                  state_d   = StCollect;
               end else if (is_bs) begin
                  state_d = StCollect;
               end
            end
            StDiscard: begin
               if (is_term) begin
                  buf_d     = '0;
                  cnt_d     = '0;
                  uid_d     = '0;
                  uid_set_d = 1'b0;
                  state_d   = StCollect;
               end
            end
            default: state_d = StCollect;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= StCollect;
         buf_q     <= '0;
         cnt_q     <= '0;
         uid_q     <= '0;
         uid_set_q <= 1'b0;
         a_q       <= '0;
         u_q       <= '0;
         rdy_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         uid_q     <= uid_d;
         uid_set_q <= uid_set_d;
         a_q       <= a_d;
         u_q       <= u_d;
         rdy_q     <= rdy_d;
         err_q     <= err_d;
      end
   end

   assign o_rdy = rdy_q;
   assign o_err = err_q;
   assign o_a   = a_q;
   assign o_u   = u_q;

endmodule
